// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - show-ahead instruction buffer between fetch and decode
//
// Purpose:
//   Circular buffer of fetch bundles. Each bundle holds the PC, PC+4,
//   instruction word, predictor enable and predictor decision. When decode
//   stalls, bundles accumulate here. Fetch stalls only when every entry is
//   occupied. A flush discards all buffered bundles in a single cycle.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   flush                     discard every entry (redirect)
//   push_valid_F/push_ready_F fetch-side handshake
//   PC_out_F, normal_F,       fetch bundle: PC, PC+4, instruction,
//   inst_F, BP_en_F,          branch flag and predictor decision
//   BP_decision_F
//   pop_ready_DE/pop_valid_DE decode-side handshake
//   PC_out_DE ... BP_decision_DE  head bundle, read combinationally
//   count                     current occupancy, 0..DEPTH

module fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push_valid_F,
    output logic                       push_ready_F,
    input  logic [WIDTH-1:0]           PC_out_F,
    input  logic [WIDTH-1:0]           normal_F,
    input  logic [WIDTH-1:0]           inst_F,
    input  logic                       BP_en_F,
    input  logic                       BP_decision_F,
    input  logic                       pop_ready_DE,
    output logic                       pop_valid_DE,
    output logic [WIDTH-1:0]           PC_out_DE,
    output logic [WIDTH-1:0]           normal_DE,
    output logic [WIDTH-1:0]           inst_DE,
    output logic                       BP_en_DE,
    output logic                       BP_decision_DE,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // NOP presented to decode whenever the queue is empty (addi x0, x0, 0).
    localparam logic [WIDTH-1:0] NOP = WIDTH'(32'h0000_0013);

    logic [WIDTH-1:0] pc_mem     [DEPTH];
    logic [WIDTH-1:0] normal_mem [DEPTH];
    logic [WIDTH-1:0] inst_mem   [DEPTH];
    logic             bp_en_mem  [DEPTH];
    logic             bp_dec_mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic push_fire;
    logic pop_fire;

    // Ready comes only from registered occupancy, so no combinational path
    // exists from decode's stall back into fetch. A full queue refuses a push
    // even when a pop happens in the same cycle.
    assign push_ready_F = (count < CW'(DEPTH));
    assign pop_valid_DE = (count != '0);

    assign push_fire = push_valid_F && push_ready_F && !flush;
    assign pop_fire  = pop_valid_DE && pop_ready_DE && !flush;

    // Pointers and occupancy. Pointer width is log2(DEPTH), so the
    // increment wraps DEPTH-1 -> 0 on its own.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_fire && !pop_fire) begin
                count <= count + CW'(1);
            end else if (pop_fire && !push_fire) begin
                count <= count - CW'(1);
            end
        end
    end

    // Bundle storage. All fields of a bundle are written together at the
    // same index so they can never be split across entries. Only reset
    // clears the contents; a flush leaves stale data behind the pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]     <= '0;
                normal_mem[i] <= '0;
                inst_mem[i]   <= '0;
                bp_en_mem[i]  <= 1'b0;
                bp_dec_mem[i] <= 1'b0;
            end
        end else if (push_fire) begin
            pc_mem[wr_ptr]     <= PC_out_F;
            normal_mem[wr_ptr] <= normal_F;
            inst_mem[wr_ptr]   <= inst_F;
            bp_en_mem[wr_ptr]  <= BP_en_F;
            bp_dec_mem[wr_ptr] <= BP_decision_F;
        end
    end

    // Show-ahead head read. An empty queue presents a NOP with all other
    // fields zero, so decode never sees stale storage.
    always_comb begin
        PC_out_DE      = '0;
        normal_DE      = '0;
        inst_DE        = NOP;
        BP_en_DE       = 1'b0;
        BP_decision_DE = 1'b0;
        if (pop_valid_DE) begin
            PC_out_DE      = pc_mem[rd_ptr];
            normal_DE      = normal_mem[rd_ptr];
            inst_DE        = inst_mem[rd_ptr];
            BP_en_DE       = bp_en_mem[rd_ptr];
            BP_decision_DE = bp_dec_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue

module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        push_valid_F;
    logic        push_ready_F;
    logic [31:0] PC_out_F;
    logic [31:0] normal_F;
    logic [31:0] inst_F;
    logic        BP_en_F;
    logic        BP_decision_F;
    logic        pop_ready_DE;
    logic        pop_valid_DE;
    logic [31:0] PC_out_DE;
    logic [31:0] normal_DE;
    logic [31:0] inst_DE;
    logic        BP_en_DE;
    logic        BP_decision_DE;
    logic [2:0]  count;

    int total;
    int bad;

    fetch_queue #(.WIDTH(32), .DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .push_valid_F   (push_valid_F),
        .push_ready_F   (push_ready_F),
        .PC_out_F       (PC_out_F),
        .normal_F       (normal_F),
        .inst_F         (inst_F),
        .BP_en_F        (BP_en_F),
        .BP_decision_F  (BP_decision_F),
        .pop_ready_DE   (pop_ready_DE),
        .pop_valid_DE   (pop_valid_DE),
        .PC_out_DE      (PC_out_DE),
        .normal_DE      (normal_DE),
        .inst_DE        (inst_DE),
        .BP_en_DE       (BP_en_DE),
        .BP_decision_DE (BP_decision_DE),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then step past the edge. Bundle fields are
    // derived from the PC: normal=pc+4, BP_en=pc[2], BP_decision=pc[3].
    task automatic drive(input logic pv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic pr, input logic fl, input logic r);
        push_valid_F  = pv;
        PC_out_F      = pc;
        normal_F      = pc + 32'd4;
        inst_F        = ins;
        BP_en_F       = pc[2];
        BP_decision_F = pc[3];
        pop_ready_DE  = pr;
        flush         = fl;
        rst           = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] pc;
        logic [31:0] hp;
        total = 0;
        bad   = 0;

        // Reset
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step();
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_push_ready", 64'(push_ready_F), 64'd1);
        check("rst_pop_valid", 64'(pop_valid_DE), 64'd0);
        check("rst_inst_nop", 64'(inst_DE), 64'h13);
        check("rst_pc", 64'(PC_out_DE), 64'd0);

        // Push 0x0, 0x4, 0x8 with decode stalled
        for (int i = 0; i < 3; i++) begin
            pc = 32'(i * 4);
            drive(1'b1, pc, pc + 32'h100, 1'b0, 1'b0, 1'b0);
            step();
            check($sformatf("fill_count_%0d", i), 64'(count), 64'(i + 1));
            check($sformatf("fill_ready_%0d", i), 64'(push_ready_F), 64'd1);
            check($sformatf("fill_head_pc_%0d", i), 64'(PC_out_DE), 64'h0);
            check($sformatf("fill_head_normal_%0d", i), 64'(normal_DE), 64'h4);
        end
        check("fill_pop_valid", 64'(pop_valid_DE), 64'd1);

        // Fourth entry fills the queue
        drive(1'b1, 32'hC, 32'h10C, 1'b0, 1'b0, 1'b0);
        step();
        check("full_count", 64'(count), 64'd4);
        check("full_ready", 64'(push_ready_F), 64'd0);

        // Fifth push is refused even though a pop happens this cycle
        drive(1'b1, 32'h10, 32'h110, 1'b1, 1'b0, 1'b0);
        #1;
        check("full_ready_with_pop", 64'(push_ready_F), 64'd0);
        step();
        check("after_full_count", 64'(count), 64'd3);
        check("after_full_ready", 64'(push_ready_F), 64'd1);
        check("after_full_head", 64'(PC_out_DE), 64'h4);

        // Push and pop every cycle for 10 cycles; pointers wrap repeatedly.
        // Queue holds 0x4, 0x8, 0xC; new pushes continue at 0x10.
        for (int k = 0; k < 10; k++) begin
            hp = 32'(4 + 4 * k);
            pc = 32'(16 + 4 * k);
            drive(1'b1, pc, pc + 32'h100, 1'b1, 1'b0, 1'b0);
            #1;
            check($sformatf("stream_pc_%0d", k), 64'(PC_out_DE), 64'(hp));
            check($sformatf("stream_normal_%0d", k), 64'(normal_DE), 64'(hp + 32'd4));
            check($sformatf("stream_inst_%0d", k), 64'(inst_DE), 64'(hp + 32'h100));
            check($sformatf("stream_bpen_%0d", k), 64'(BP_en_DE), 64'(hp[2]));
            check($sformatf("stream_bpdec_%0d", k), 64'(BP_decision_DE), 64'(hp[3]));
            step();
            check($sformatf("stream_count_%0d", k), 64'(count), 64'd3);
        end
        check("stream_end_head", 64'(PC_out_DE), 64'h2C);

        // Flush with simultaneous push and pop: both dropped
        drive(1'b1, 32'h40, 32'h140, 1'b1, 1'b1, 1'b0);
        step();
        check("flush_count", 64'(count), 64'd0);
        check("flush_pop_valid", 64'(pop_valid_DE), 64'd0);
        check("flush_inst_nop", 64'(inst_DE), 64'h13);
        check("flush_ready", 64'(push_ready_F), 64'd1);

        // Empty queue push with decode ready: no pop in the push cycle
        drive(1'b1, 32'h80, 32'h00A00093, 1'b1, 1'b0, 1'b0);
        #1;
        check("empty_push_pop_valid", 64'(pop_valid_DE), 64'd0);
        step();
        check("empty_push_pop_valid_next", 64'(pop_valid_DE), 64'd1);
        check("empty_push_inst", 64'(inst_DE), 64'h00A00093);
        check("empty_push_pc", 64'(PC_out_DE), 64'h80);
        check("empty_push_count", 64'(count), 64'd1);

        // Second entry, then reset mid-stream
        drive(1'b1, 32'h84, 32'h00100113, 1'b0, 1'b0, 1'b0);
        step();
        check("pre_rst_count", 64'(count), 64'd2);
        drive(1'b1, 32'h88, 32'h00200193, 1'b1, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_ready", 64'(push_ready_F), 64'd1);
        check("mid_rst_pop_valid", 64'(pop_valid_DE), 64'd0);
        check("mid_rst_pc", 64'(PC_out_DE), 64'd0);
        check("mid_rst_normal", 64'(normal_DE), 64'd0);
        check("mid_rst_inst", 64'(inst_DE), 64'h13);
        check("mid_rst_bpen", 64'(BP_en_DE), 64'd0);
        check("mid_rst_bpdec", 64'(BP_decision_DE), 64'd0);

        // Pointers restart at 0 after reset
        drive(1'b1, 32'h200, 32'h300, 1'b0, 1'b0, 1'b0);
        step();
        check("post_rst_head", 64'(PC_out_DE), 64'h200);
        check("post_rst_count", 64'(count), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
